// File: rtl/product_bcd_display_pkg.sv
// rtl/product_bcd_display_pkg.sv - shared constants, FSM states and 7-segment lookup
package product_bcd_display_pkg;

    localparam int NUM_BCD_DIGITS = 5;
    localparam int NUM_ANODES     = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_LATCH   = 2'd2
    } dd_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low cathodes, bit order {g,f,e,d,c,b,a}; 10..15 never occur and stay dark.
    function automatic logic [6:0] seg_lookup(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/product_bcd_display_if.sv
// rtl/product_bcd_display_if.sv - product input handshake and display output bundle
interface product_bcd_display_if;
    logic [15:0] product;
    logic        product_valid;
    logic        busy;
    logic [19:0] bcd;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;

    modport master (output product, product_valid, input busy, bcd, seg, dp, an);
    modport slave  (input product, product_valid, output busy, bcd, seg, dp, an);
endinterface

// File: rtl/bin2bcd_dd.sv
// rtl/bin2bcd_dd.sv - sequential double-dabble, one product bit per clock
module bin2bcd_dd
    import product_bcd_display_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] product,
    input  logic        product_valid,
    output logic        busy,
    output logic [19:0] bcd
);

    dd_state_e   state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [19:0] scratch_q, scratch_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] bcd_q, bcd_d;
    logic [19:0] adj;

    // Add-3 correction on every nibble before the shift keeps each nibble a valid BCD digit.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < NUM_BCD_DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (product_valid) begin
                    shift_d   = product;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                {scratch_d, shift_d} = {adj[18:0], shift_q, 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                bcd_d   = scratch_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign bcd  = bcd_q;

endmodule

// File: rtl/product_bcd_display.sv
// rtl/product_bcd_display.sv - product to BCD conversion and multiplexed 7-segment drive
module product_bcd_display
    import product_bcd_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LEAD  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    product_bcd_display_if.slave  pif
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic                  busy_w;
    logic [19:0]           bcd_w;
    logic [CNT_W-1:0]      refresh_q, refresh_d;
    logic [2:0]            idx_q, idx_d;
    logic [NUM_ANODES-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic [19:0]           upper;
    logic [3:0]            digit;
    logic                  lit;

    bin2bcd_dd u_dd (
        .clk           (clk),
        .reset         (reset),
        .product       (pif.product),
        .product_valid (pif.product_valid),
        .busy          (busy_w),
        .bcd           (bcd_w)
    );

    always_comb begin
        refresh_d = refresh_q + CNT_W'(1);
        idx_d     = idx_q;
        if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            idx_d     = idx_q + 3'd1;
        end
    end

    // upper holds digits idx..4; if all are zero the slot is a leading zero.
    always_comb begin
        upper = bcd_w >> {idx_q, 2'b00};
        digit = upper[3:0];
        lit   = (idx_q < 3'(NUM_BCD_DIGITS)) &&
                ((idx_q == 3'd0) || !BLANK_LEAD || (upper != '0));
        an_d  = '1;
        seg_d = SEG_BLANK;
        if (lit) begin
            an_d  = ~(NUM_ANODES'(1) << idx_q);
            seg_d = seg_lookup(digit);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh_q <= '0;
            idx_q     <= '0;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
        end else begin
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign pif.busy = busy_w;
    assign pif.bcd  = bcd_w;
    assign pif.an   = an_q;
    assign pif.seg  = seg_q;
    assign pif.dp   = 1'b1;

endmodule

// File: tb/tb_product_bcd_display.sv
// tb/tb_product_bcd_display.sv - bench for product_bcd_display with a decimal reference model
module tb_product_bcd_display;

    localparam int DIV_A = 4;
    localparam int DIV_B = 3;

    typedef struct {
        logic [15:0] product;
        logic [19:0] bcd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] product = '0;
    logic        valid = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    product_bcd_display_if ifa ();
    product_bcd_display_if ifb ();

    assign ifa.product       = product;
    assign ifa.product_valid = valid;
    assign ifb.product       = product;
    assign ifb.product_valid = valid;

    product_bcd_display #(.REFRESH_DIV(DIV_A), .BLANK_LEAD(1'b1)) dut_a (
        .clk(clk), .reset(reset), .pif(ifa.slave));
    product_bcd_display #(.REFRESH_DIV(DIV_B), .BLANK_LEAD(1'b0)) dut_b (
        .clk(clk), .reset(reset), .pif(ifb.slave));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        return {4'(v / 10000 % 10), 4'(v / 1000 % 10), 4'(v / 100 % 10),
                4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Expected {an, seg} after e clock edges since reset, showing decimal value val.
    function automatic logic [14:0] exp_disp(input int e, input int div, input bit blank, input int val);
        int idx, n, v, p;
        if (e == 0) return {8'hFF, 7'h7F};
        idx = ((e - 1) / div) % 8;
        n = 1;
        v = val;
        while (v >= 10) begin
            n++;
            v = v / 10;
        end
        if (idx < (blank ? n : 5)) begin
            p = 1;
            for (int k = 0; k < idx; k++) p = p * 10;
            return {~8'(1 << idx), seg_tab[(val / p) % 10]};
        end
        return {8'hFF, 7'h7F};
    endfunction

    // Reference: an accepted product becomes visible 17 edges later; display lags by one edge.
    int m_cnt, m_val, m_pend, disp_val, edges;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt    <= 0;
            m_val    <= 0;
            m_pend   <= 0;
            disp_val <= 0;
            edges    <= 0;
        end else begin
            edges    <= edges + 1;
            disp_val <= m_val;
            if (m_cnt == 0) begin
                if (valid) begin
                    m_cnt  <= 17;
                    m_pend <= int'(product);
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) m_val <= m_pend;
            end
        end
    end

    always @(negedge clk) begin
        check("busy_a", 32'(ifa.busy), 32'(m_cnt != 0));
        check("busy_b", 32'(ifb.busy), 32'(m_cnt != 0));
        check("bcd_a", 32'(ifa.bcd), 32'(to_bcd(m_val)));
        check("bcd_b", 32'(ifb.bcd), 32'(to_bcd(m_val)));
        check("dp", 32'({ifa.dp, ifb.dp}), 32'h3);
        check("disp_a", 32'({ifa.an, ifa.seg}), 32'(exp_disp(edges, DIV_A, 1'b1, disp_val)));
        check("disp_b", 32'({ifb.an, ifb.seg}), 32'(exp_disp(edges, DIV_B, 1'b0, disp_val)));
    end

    task automatic run_conv(input logic [15:0] p, input logic [19:0] exp_bcd, input string name);
        int n;
        @(negedge clk);
        product = p;
        valid   = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        n = 0;
        while (ifa.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 32'(n), 32'd17);
        check({name, "_bcd"}, 32'(ifa.bcd), 32'(exp_bcd));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (ifa.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({name, "_idle_timeout"}, 32'(ifa.busy), 32'd0);
    endtask

    vec_t vecs [10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, mask_a, mask_b;
        logic [7:0]  an_exp [8];
        logic [6:0]  seg_exp [3];
        logic [15:0] r;

        vecs = '{'{16'd0, 20'h00000}, '{16'd1, 20'h00001}, '{16'd9, 20'h00009},
                 '{16'd10, 20'h00010}, '{16'd99, 20'h00099}, '{16'd1234, 20'h01234},
                 '{16'd9999, 20'h09999}, '{16'd10000, 20'h10000}, '{16'd4096, 20'h04096},
                 '{16'hFFFF, 20'h65535}};

        repeat (2) @(negedge clk);
        check("reset_busy", 32'(ifa.busy), 32'd0);
        check("reset_bcd", 32'(ifa.bcd), 32'd0);
        check("reset_an", 32'(ifa.an), 32'hFF);
        check("reset_seg", 32'(ifa.seg), 32'h7F);
        reset = 1'b1;

        foreach (vecs[i]) run_conv(vecs[i].product, vecs[i].bcd, "vec");

        for (int i = 0; i < 20; i++) begin
            r = 16'($urandom_range(0, 65535));
            run_conv(r, to_bcd(int'(r)), "rand");
        end

        // Async reset in the middle of a conversion.
        @(negedge clk);
        product = 16'd1234;
        valid   = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", 32'(ifa.busy), 32'd0);
        check("abort_bcd", 32'(ifa.bcd), 32'd0);
        check("abort_an_a", 32'(ifa.an), 32'hFF);
        check("abort_seg_a", 32'(ifa.seg), 32'h7F);
        check("abort_an_b", 32'(ifb.an), 32'hFF);
        @(negedge clk);
        reset = 1'b1;

        // Zero: A shows only the units digit, B cycles all five digits.
        run_conv(16'd0, 20'h00000, "zero");
        mask_a = 0;
        mask_b = 0;
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            mask_a = mask_a | int'(~ifa.an);
            mask_b = mask_b | int'(~ifb.an);
            if (ifb.an != 8'hFF) check("zero_seg_b", 32'(ifb.seg), 32'h40);
            if (ifa.an != 8'hFF) check("zero_seg_a", 32'(ifa.seg), 32'h40);
        end
        check("zero_mask_a", 32'(mask_a & 8'hFF), 32'h01);
        check("zero_mask_b", 32'(mask_b & 8'hFF), 32'h1F);

        // Second pulse at E5 is ignored.
        @(negedge clk);
        product = 16'd1234;
        valid   = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        product = 16'd9;
        valid   = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        wait_idle("ignore");
        check("ignore_bcd", 32'(ifa.bcd), 32'h01234);
        repeat (3) @(negedge clk);
        check("ignore_stays_idle", 32'(ifa.busy), 32'd0);

        // Valid held through LATCH restarts on the first IDLE cycle.
        @(negedge clk);
        product = 16'd100;
        valid   = 1'b1;
        repeat (17) @(negedge clk);
        check("hold_latch_busy", 32'(ifa.busy), 32'd1);
        product = 16'd42;
        @(negedge clk);
        check("hold_gap_busy", 32'(ifa.busy), 32'd0);
        check("hold_first_bcd", 32'(ifa.bcd), 32'h00100);
        @(negedge clk);
        check("hold_restart_busy", 32'(ifa.busy), 32'd1);
        valid = 1'b0;
        wait_idle("hold");
        check("hold_final_bcd", 32'(ifa.bcd), 32'h00042);

        // Scan sequence of DUT A for 305 with leading-zero blanking.
        run_conv(16'd305, 20'h00305, "scan");
        an_exp  = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        seg_exp = '{7'h12, 7'h40, 7'h30};
        n = 0;
        while (ifa.an == 8'hFE && n < 64) begin
            n++;
            @(negedge clk);
        end
        while (ifa.an != 8'hFE && n < 64) begin
            n++;
            @(negedge clk);
        end
        check("scan_align", 32'(ifa.an), 32'hFE);
        for (int k = 0; k < 32; k++) begin
            check("scan_an", 32'(ifa.an), 32'(an_exp[k / 4]));
            if (k < 12) check("scan_seg", 32'(ifa.seg), 32'(seg_exp[k / 4]));
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
